sobel_gradient: RTL and testbench
=================================

// Module: sobel_gradient
// PURPOSE
//   Streaming 3x3 Sobel gradient generator. It consumes raster-order grayscale pixels
//   from the pre-processing stage and produces signed Gx/Gy per pixel. These feed the
//   downstream squared-magnitude edge detector.
//   Holds two line buffers and a 3x3 window. There is no backpressure.
// PARAMETERS
//   IMG_WIDTH   640  pixels per line (>=3)
//   IMG_HEIGHT  480  lines per frame (>=3)
//   PIX_W       8    grayscale pixel width; gradient width is fixed at 12 (|G|max=4*255=1020)
// PORTS
//   clk         in   1      single clock, all logic on posedge
//   rst         in   1      synchronous, active-high reset
//   pix_valid   in   1      pix_data valid this cycle; may have arbitrary gaps
//   pix_sof     in   1      qualifies the first pixel of a frame; sampled only with pix_valid
//   pix_data    in   PIX_W  unsigned grayscale pixel
//   grad_valid  out  1      Gx/Gy/out_row/out_col valid this cycle
//   Gx          out  12     signed horizontal gradient (two's complement)
//   Gy          out  12     signed vertical gradient (two's complement)
//   out_row     out  clog2(IMG_HEIGHT)  row of the input pixel that produced this output
//   out_col     out  clog2(IMG_WIDTH)   column of the input pixel that produced this output
//   frame_done  out  1      1-cycle pulse coincident with the output for pixel (H-1, W-1)
// BEHAVIOUR
//   Reset: grad_valid, Gx, Gy, out_row, out_col, frame_done = 0. Pipeline valids cleared.
//     Input row/col counters = 0. Line-buffer and window contents are NOT cleared
//     (border masking makes them don't-care).
//   Counters: advance only on pix_valid. col wraps W-1 -> 0 and increments row.
//     row wraps H-1 -> 0.
//     pix_sof & pix_valid forces the current pixel to (0,0); counters then continue from there.
//   Line buffers: lb1[col] holds row r-1 and lb2[col] holds row r-2.
//     On pix_valid: read lb1[col] and lb2[col], then write lb2[col] <= lb1[col] and lb1[col] <= pix_data.
//     Read-before-write in the same cycle.
//   Window: on pix_valid, shift left. New right column = {lb2[col], lb1[col], pix_data}
//     (top..bottom). p[i][j]: i = 0 top .. 2 bottom; j = 0 left .. 2 right.
//     The window center is input pixel (row-1, col-1).
//   Stage 1 (cycle N+1): the window, border flag, row/col and valid are registered.
//     border = (row < 2) | (col < 2).
//   Stage 2 (cycle N+2): outputs registered.
//     Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
//     Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
//     Compute in 12-bit signed arithmetic with zero-extended pixels. No saturation is
//     needed, since the range is [-1020, +1020].
//     If border = 1, then Gx = Gy = 0 (grad_valid is still asserted).
//   Latency: exactly 2 cycles, pix_valid -> grad_valid.
//     One output per input pixel, W*H outputs per frame, in input order. Gaps are preserved.
//   Frame end: frame_done = grad_valid & out_row == H-1 & out_col == W-1.
//     Right and bottom image edges are never flushed; there is no extra output.
//   Simultaneous events: pix_sof on a pixel whose counters were already (0,0) is a no-op.
//     An early pix_sof abandons the partial frame; no frame_done is issued for it.
//     Outputs already in flight still emerge with their original coordinates.
//   Mid-operation rst: it overrides pix_valid. grad_valid = 0 in the cycle after rst is
//     sampled. The in-flight outputs are dropped. The next pixel is treated as (0,0).
//   pix_sof without pix_valid is ignored. Outputs hold their last value when grad_valid = 0.
// TESTING  (W=8, H=6 unless noted)
//   1 Uniform frame, all pixels = 128, gapless
//     -> 48 outputs, all Gx = Gy = 0; frame_done only on output 48; latency 2 cycles.
//   2 Vertical step (col < 4 -> 0, else 255)
//     -> at out_row >= 2, out_col = 4 and 5 (centers 3 and 4): Gx = +1020, Gy = 0.
//     All other outputs: 0.
//   3 Horizontal step (row < 3 -> 0, else 255)
//     -> out_row = 3 and 4, out_col >= 2: Gy = +1020, Gx = 0.
//     Inverted image -> Gy = -1020 (12'hC04).
//   4 Test 2 with random 0-3 cycle gaps on pix_valid
//     -> output sequence identical to the gapless run; each grad_valid is exactly 2 cycles
//     after its pix_valid.
//   5 pix_sof asserted at input (3,5) mid-frame
//     -> that pixel gets out_row = 0, out_col = 0; the next 2 rows plus cols 0-1 give zero
//     gradients; no frame_done until 48 pixels after the sof.
//   6 rst pulsed 1 cycle during row 2, with valid data in the pipeline
//     -> grad_valid = 0 the next cycle; outputs zeroed; the next pixel is reported as (0,0).

Source files
------------

// File: rtl/sobel_gradient.sv
// sobel_gradient: streaming 3x3 Sobel Gx/Gy generator with two line buffers and a 2-stage output pipeline
module sobel_gradient #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pix_valid,
    input  logic                          pix_sof,
    input  logic [PIX_W-1:0]              pix_data,
    output logic                          grad_valid,
    output logic [11:0]                   Gx,
    output logic [11:0]                   Gy,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          frame_done
);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    logic [RW-1:0]    row, cur_row, s1_row;
    logic [CW-1:0]    col, cur_col, s1_col;
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] lb2 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1_rd, lb2_rd;
    logic [PIX_W-1:0] p [3][3];
    logic             s1_valid, s1_border;
    logic [11:0]      gx_c, gy_c;

    function automatic logic [11:0] z(input logic [PIX_W-1:0] v);
        return 12'(v);
    endfunction

    // Coordinates of the incoming pixel (sof forces 0,0) and read-before-write line buffer taps
    always_comb begin
        cur_row = pix_sof ? '0 : row;
        cur_col = pix_sof ? '0 : col;
        lb1_rd  = lb1[cur_col];
        lb2_rd  = lb2[cur_col];
    end

    // Raster counters advance per accepted pixel, wrapping at line and frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (pix_valid) begin
            col <= (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
            row <= (cur_col != COL_LAST) ? cur_row : (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        end
    end

    // Line buffers and window are data-only storage; border masking hides stale contents
    always_ff @(posedge clk) begin
        if (pix_valid && !rst) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= pix_data;
            for (int i = 0; i < 3; i++) begin
                p[i][0] <= p[i][1];
                p[i][1] <= p[i][2];
            end
            p[0][2] <= lb2_rd;
            p[1][2] <= lb1_rd;
            p[2][2] <= pix_data;
        end
    end

    // Stage 1: capture valid, coordinates and border flag alongside the freshly shifted window
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_border <= 1'b0;
            s1_row    <= '0;
            s1_col    <= '0;
        end else begin
            s1_valid <= pix_valid;
            if (pix_valid) begin
                s1_border <= (cur_row < RW'(2)) || (cur_col < CW'(2));
                s1_row    <= cur_row;
                s1_col    <= cur_col;
            end
        end
    end

    // Sobel kernels in 12-bit two's complement; range never exceeds +/-1020
    always_comb begin
        gx_c = (z(p[0][2]) + (z(p[1][2]) << 1) + z(p[2][2])) - (z(p[0][0]) + (z(p[1][0]) << 1) + z(p[2][0]));
        gy_c = (z(p[2][0]) + (z(p[2][1]) << 1) + z(p[2][2])) - (z(p[0][0]) + (z(p[0][1]) << 1) + z(p[0][2]));
    end

    // Stage 2: register outputs, zero gradients on the border, hold values while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            grad_valid <= 1'b0;
            Gx         <= '0;
            Gy         <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            grad_valid <= s1_valid;
            frame_done <= s1_valid && (s1_row == ROW_LAST) && (s1_col == COL_LAST);
            if (s1_valid) begin
                Gx      <= s1_border ? '0 : gx_c;
                Gy      <= s1_border ? '0 : gy_c;
                out_row <= s1_row;
                out_col <= s1_col;
            end
        end
    end
endmodule

// File: tb/tb_sobel_gradient.sv
// tb_sobel_gradient: randomized Sobel stream checked against an image-array reference model
module tb_sobel_gradient;
    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst, pix_valid, pix_sof;
    logic [7:0]  pix_data;
    logic        grad_valid, frame_done;
    logic [11:0] Gx, Gy;
    logic [2:0]  out_row, out_col;

    sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .grad_valid(grad_valid), .Gx(Gx), .Gy(Gy), .out_row(out_row), .out_col(out_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int r, c, gx, gy, fd, t;
    } exp_t;

    exp_t q[$];
    int   img[H][W];
    int   mr = 0, mc = 0;
    int   n_fd = 0, n_gxp = 0, n_gyp = 0, n_gyn = 0;

    // Reference: store each pixel at its raster coordinate, Sobel over the 3x3 ending at it
    task automatic model_px(int pix, bit sof);
        exp_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = pix;
        e.r = mr;
        e.c = mc;
        e.t = cyc + 2;
        e.gx = 0;
        e.gy = 0;
        if (mr >= 2 && mc >= 2) begin
            e.gx = (img[mr-2][mc] + 2*img[mr-1][mc] + img[mr][mc])
                 - (img[mr-2][mc-2] + 2*img[mr-1][mc-2] + img[mr][mc-2]);
            e.gy = (img[mr][mc-2] + 2*img[mr][mc-1] + img[mr][mc])
                 - (img[mr-2][mc-2] + 2*img[mr-2][mc-1] + img[mr-2][mc]);
        end
        e.fd = (mr == H-1 && mc == W-1) ? 1 : 0;
        q.push_back(e);
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr + 1) % H;
        end
    endtask

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (grad_valid) begin
            if (q.size() == 0) check("unexpected_out", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("latency", cyc, e.t);
                check("out_row", int'(out_row), e.r);
                check("out_col", int'(out_col), e.c);
                check("Gx", int'($signed(Gx)), e.gx);
                check("Gy", int'($signed(Gy)), e.gy);
                check("frame_done", int'(frame_done), e.fd);
                n_fd += int'(frame_done);
                if ($signed(Gx) == 12'sd1020) n_gxp++;
                if ($signed(Gy) == 12'sd1020) n_gyp++;
                if ($signed(Gy) == -12'sd1020) n_gyn++;
            end
        end else begin
            if (q.size() > 0 && q[0].t <= cyc) begin
                check("missing_out", 0, 1);
                void'(q.pop_front());
            end
            if (frame_done) check("frame_done_stray", 1, 0);
        end
    end

    function automatic int pixf(int kind, int r, int c, bit inv);
        int v;
        v = (kind == 0) ? 128 : (kind == 1) ? ((c < 4) ? 0 : 255) :
            (kind == 2) ? ((r < 3) ? 0 : 255) : int'($urandom_range(255));
        return inv ? 255 - v : v;
    endfunction

    task automatic px(int p, bit sof, int maxgap);
        repeat ($urandom_range(maxgap)) begin
            @(posedge clk);
            #1 pix_valid = 1'b0;
            pix_sof  = 1'($urandom_range(1));
            pix_data = 8'($urandom);
        end
        @(posedge clk);
        #1 pix_valid = 1'b1;
        pix_sof  = sof;
        pix_data = 8'(p);
        model_px(p, sof);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1 pix_valid = 1'b0;
            pix_sof = 1'b0;
        end
    endtask

    task automatic frame(int kind, bit inv, int maxgap, bit first_sof);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                px(pixf(kind, r, c, inv), first_sof && r == 0 && c == 0, maxgap);
    endtask

    task automatic drain();
        idle(4);
        check("queue_drained", q.size(), 0);
    endtask

    task automatic check_zeroed(string tag);
        check({tag, "_grad_valid"}, int'(grad_valid), 0);
        check({tag, "_Gx"}, int'(Gx), 0);
        check({tag, "_Gy"}, int'(Gy), 0);
        check({tag, "_out_row"}, int'(out_row), 0);
        check({tag, "_out_col"}, int'(out_col), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fd0, gx0, gyp0, gyn0;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_zeroed("reset");

        // Uniform gapless frame
        fd0 = n_fd;
        frame(0, 1'b0, 0, 1'b1);
        drain();
        check("t1_frame_done_count", n_fd - fd0, 1);

        // Vertical step
        gx0 = n_gxp;
        frame(1, 1'b0, 0, 1'b1);
        drain();
        check("t2_gx_1020_count", n_gxp - gx0, 8);

        // Horizontal step and its inverse
        gyp0 = n_gyp;
        frame(2, 1'b0, 0, 1'b1);
        drain();
        check("t3_gy_pos_count", n_gyp - gyp0, 12);
        gyn0 = n_gyn;
        frame(2, 1'b1, 0, 1'b1);
        drain();
        check("t3_gy_neg_count", n_gyn - gyn0, 12);

        // Vertical step with random gaps
        gx0 = n_gxp;
        frame(1, 1'b0, 3, 1'b1);
        drain();
        check("t4_gx_1020_count", n_gxp - gx0, 8);

        // Random images with gaps
        for (int k = 0; k < 3; k++) begin
            fd0 = n_fd;
            frame(3, 1'b0, 3, 1'b1);
            drain();
            check("rand_frame_done_count", n_fd - fd0, 1);
        end

        // Early sof at (3,5)
        fd0 = n_fd;
        for (int i = 0; i < 29; i++) px(int'($urandom_range(255)), i == 0, 1);
        for (int i = 0; i < 48; i++) px(int'($urandom_range(255)), i == 0, 1);
        drain();
        check("t5_frame_done_count", n_fd - fd0, 1);

        // Reset during row 2 with data in flight; valid held high during reset
        for (int i = 0; i < 20; i++) px(int'($urandom_range(255)), i == 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        pix_valid = 1'b1;
        pix_data = 8'($urandom);
        while (q.size() > 0 && q[$].t > cyc) void'(q.pop_back());
        mr = 0;
        mc = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        check_zeroed("mid_reset");
        fd0 = n_fd;
        frame(3, 1'b0, 2, 1'b0);
        drain();
        check("t6_frame_done_count", n_fd - fd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
